// File: rtl/alu_muldiv_seq_if.sv
// Execute-stage link between the datapath and the multi-cycle MULTU/DIVU sequencer.
// Carries the request, the result and the borrowed-ALU drive.
interface alu_muldiv_seq_if;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [31:0] alu_result;

  // Datapath side: issues requests and supplies the shared ALU result.
  modport master (
    output start, op, opa, opb, alu_result,
    input  busy, done, hi, lo, div_zero, alu_req, alu_a, alu_b, alu_fun, alu_sign
  );

  // Sequencer side.
  modport slave (
    input  start, op, opa, opb, alu_result,
    output busy, done, hi, lo, div_zero, alu_req, alu_a, alu_b, alu_fun, alu_sign
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply / restoring divide that iterates the shared ALU
// 32 times per operation and returns HI/LO with a one-cycle done pulse.
module alu_muldiv_seq (
  input logic              clk,
  input logic              reset,
  alu_muldiv_seq_if.slave  bus
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 5;
  localparam int unsigned FW = 6;

  localparam logic [FW-1:0] FUN_ADD  = 6'b000000;
  localparam logic [FW-1:0] FUN_SUB  = 6'b000001;
  localparam logic [CW-1:0] CNT_LAST = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_hi_q, acc_hi_d;   // P_hi for MUL, R for DIV
  logic [W-1:0]  acc_lo_q, acc_lo_d;   // P_lo for MUL, Q for DIV
  logic [W-1:0]  opd_q, opd_d;         // M for MUL, D for DIV
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          dz_q, dz_d;

  logic [W-1:0]  r_shift_c;
  logic [W-1:0]  alu_a_c;
  logic [W-1:0]  alu_b_c;
  logic [FW-1:0] alu_fun_c;
  logic [W-1:0]  sum_c;
  logic          carry_c;
  logic          borrow_c;

  assign r_shift_c = {acc_hi_q[W-2:0], acc_lo_q[W-1]};
  assign sum_c     = bus.alu_result;

  // ALU operand/function drive, decoded from registered state only.
  always_comb begin
    alu_a_c   = '0;
    alu_b_c   = '0;
    alu_fun_c = FUN_ADD;
    case (state_q)
      S_MUL: begin
        alu_a_c   = acc_hi_q;
        alu_b_c   = opd_q;
        alu_fun_c = FUN_ADD;
      end
      S_DIV: begin
        alu_a_c   = r_shift_c;
        alu_b_c   = opd_q;
        alu_fun_c = FUN_SUB;
      end
      default: ;
    endcase
  end

  // Carry-out of the add and borrow of the subtract, recovered from sign bits.
  always_comb begin
    carry_c  = (alu_a_c[W-1] & alu_b_c[W-1]) |
               ((alu_a_c[W-1] | alu_b_c[W-1]) & ~sum_c[W-1]);
    borrow_c = (~alu_a_c[W-1] & alu_b_c[W-1]) |
               (~(alu_a_c[W-1] ^ alu_b_c[W-1]) & sum_c[W-1]);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opd_d    = opd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d = '0;
          dz_d  = 1'b0;
          if (!bus.op) begin
            state_d  = S_MUL;
            acc_hi_d = '0;
            acc_lo_d = bus.opb;
            opd_d    = bus.opa;
          end else if (bus.opb != '0) begin
            state_d  = S_DIV;
            acc_hi_d = '0;
            acc_lo_d = bus.opa;
            opd_d    = bus.opb;
          end else begin
            // Divide by zero completes immediately without touching the ALU.
            state_d = S_DONE;
            hi_d    = bus.opa;
            lo_d    = '1;
            dz_d    = 1'b1;
          end
        end
      end

      S_MUL: begin
        if (acc_lo_q[0]) begin
          acc_hi_d = {carry_c, sum_c[W-1:1]};
          acc_lo_d = {sum_c[0], acc_lo_q[W-1:1]};
        end else begin
          acc_hi_d = {1'b0, acc_hi_q[W-1:1]};
          acc_lo_d = {acc_hi_q[0], acc_lo_q[W-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          hi_d    = acc_hi_d;
          lo_d    = acc_lo_d;
        end
      end

      S_DIV: begin
        // Overflow of the shifted remainder means it certainly exceeds D.
        if (acc_hi_q[W-1] | ~borrow_c) begin
          acc_hi_d = sum_c;
          acc_lo_d = {acc_lo_q[W-2:0], 1'b1};
        end else begin
          acc_hi_d = r_shift_c;
          acc_lo_d = {acc_lo_q[W-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          hi_d    = acc_hi_d;
          lo_d    = acc_lo_d;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opd_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opd_q    <= opd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.alu_req  = (state_q == S_MUL) || (state_q == S_DIV);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;
  assign bus.alu_a    = alu_a_c;
  assign bus.alu_b    = alu_b_c;
  assign bus.alu_fun  = alu_fun_c;
  assign bus.alu_sign = 1'b0;

endmodule
